main_control_fsm: RTL

Multi-cycle main control unit for the RV32 subset core (lh, sh, bne, add, sll, or, andi). It decodes the 7-bit opcode of the instruction register and sequences the datapath through FETCH/DECODE/EXEC/MEM/WB. It produces the 2-bit `alu_op` consumed by the ALU control block, plus all datapath enables. It sits between the instruction register and the datapath, and is the upstream end of the ALUop interface.

---
 rtl/main_control_fsm_if.sv | 31 +++
 rtl/main_control_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath/fetch/memory side (slave).
// Carries the instruction handshake, the memory-ready return and every datapath enable.
interface main_control_fsm_if;
    logic       instr_valid;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       retire;
    logic       busy;
    logic       illegal;

    modport master (
        input  instr_valid, opcode, mem_ready,
        output ir_write, pc_write, alu_op, alu_src, branch, mem_read, mem_write,
               reg_write, mem_to_reg, retire, busy, illegal
    );

    modport slave (
        output instr_valid, opcode, mem_ready,
        input  ir_write, pc_write, alu_op, alu_src, branch, mem_read, mem_write,
               reg_write, mem_to_reg, retire, busy, illegal
    );
endinterface

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the RV32 subset core (lh, sh, bne, add, sll, or, andi).
// Define CTRL_ILLEGAL_TRAP_EN to trap unsupported opcodes in a sticky ILLEGAL state; otherwise they retire as NOPs.
module main_control_fsm (
    input  logic                      clk,
    input  logic                      rst_n,
    main_control_fsm_if.master        ctrl
);

    localparam logic [2:0] ST_FETCH   = 3'd0;
    localparam logic [2:0] ST_DECODE  = 3'd1;
    localparam logic [2:0] ST_EXEC    = 3'd2;
    localparam logic [2:0] ST_MEM     = 3'd3;
    localparam logic [2:0] ST_WB      = 3'd4;
    localparam logic [2:0] ST_ILLEGAL = 3'd5;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_ANDI = 7'b0010011;
    localparam logic [6:0] OPC_LH   = 7'b0000011;
    localparam logic [6:0] OPC_SH   = 7'b0100011;
    localparam logic [6:0] OPC_BNE  = 7'b1100011;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_ANDI = 3'd1;
    localparam logic [2:0] CLS_LH   = 3'd2;
    localparam logic [2:0] CLS_SH   = 3'd3;
    localparam logic [2:0] CLS_BNE  = 3'd4;
    localparam logic [2:0] CLS_NONE = 3'd7;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_RT  = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b11;

    function automatic logic [2:0] classify(input logic [6:0] opc);
        logic [2:0] cls;
        case (opc)
            OPC_R:    cls = CLS_R;
            OPC_ANDI: cls = CLS_ANDI;
            OPC_LH:   cls = CLS_LH;
            OPC_SH:   cls = CLS_SH;
            OPC_BNE:  cls = CLS_BNE;
            default:  cls = CLS_NONE;
        endcase
        return cls;
    endfunction

    logic [2:0] state_r;
    logic [2:0] state_nx_s;
    logic [2:0] op_q_r;
    logic [2:0] decode_cls_s;
    logic       decode_legal_s;

    logic       ir_write_s;
    logic       pc_write_s;
    logic [1:0] alu_op_s;
    logic       alu_src_s;
    logic       branch_s;
    logic       mem_read_s;
    logic       mem_write_s;
    logic       reg_write_s;
    logic       mem_to_reg_s;
    logic       retire_s;
    logic       busy_s;
    logic       illegal_s;

    assign decode_cls_s   = classify(ctrl.opcode);
    assign decode_legal_s = (decode_cls_s != CLS_NONE);

    // State register and latched instruction class.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_FETCH;
            op_q_r  <= CLS_R;
        end else begin
            state_r <= state_nx_s;
            if ((state_r == ST_DECODE) && decode_legal_s) begin
                op_q_r <= decode_cls_s;
            end else begin
                op_q_r <= op_q_r;
            end
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (ctrl.instr_valid) state_nx_s = ST_DECODE;
                else                  state_nx_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (decode_legal_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_nx_s = ST_ILLEGAL;
`else
                    state_nx_s = ST_FETCH;
`endif
                end
            end
            ST_EXEC: begin
                case (op_q_r)
                    CLS_BNE:         state_nx_s = ST_FETCH;
                    CLS_LH, CLS_SH:  state_nx_s = ST_MEM;
                    CLS_R, CLS_ANDI: state_nx_s = ST_WB;
                    default:         state_nx_s = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (ctrl.mem_ready) begin
                    if (op_q_r == CLS_LH) state_nx_s = ST_WB;
                    else                  state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_MEM;
                end
            end
            ST_WB: state_nx_s = ST_FETCH;
            ST_ILLEGAL: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                state_nx_s = ST_ILLEGAL;
`else
                state_nx_s = ST_FETCH;
`endif
            end
            default: state_nx_s = ST_FETCH;
        endcase
    end

    // Output decode: state and op_q_r, plus the fetch handshake, memory completion and NOP retire.
    always_comb begin
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        alu_op_s     = ALU_ADD;
        alu_src_s    = 1'b0;
        branch_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        retire_s     = 1'b0;
        busy_s       = 1'b0;
        illegal_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (ctrl.instr_valid) begin
                    ir_write_s = 1'b1;
                    pc_write_s = 1'b1;
                end else begin
                    ir_write_s = 1'b0;
                    pc_write_s = 1'b0;
                end
            end
            ST_DECODE: begin
                busy_s = 1'b1;
`ifndef CTRL_ILLEGAL_TRAP_EN
                retire_s = ~decode_legal_s;
`endif
            end
            ST_EXEC: begin
                busy_s = 1'b1;
                case (op_q_r)
                    CLS_LH, CLS_SH: begin
                        alu_op_s  = ALU_ADD;
                        alu_src_s = 1'b1;
                    end
                    CLS_BNE: begin
                        alu_op_s = ALU_SUB;
                        branch_s = 1'b1;
                        retire_s = 1'b1;
                    end
                    CLS_R: alu_op_s = ALU_RT;
                    CLS_ANDI: begin
                        alu_op_s  = ALU_AND;
                        alu_src_s = 1'b1;
                    end
                    default: alu_op_s = ALU_ADD;
                endcase
            end
            ST_MEM: begin
                busy_s      = 1'b1;
                alu_src_s   = 1'b1;
                mem_read_s  = (op_q_r == CLS_LH);
                mem_write_s = (op_q_r == CLS_SH);
                retire_s    = (op_q_r == CLS_SH) && ctrl.mem_ready;
            end
            ST_WB: begin
                busy_s       = 1'b1;
                reg_write_s  = 1'b1;
                mem_to_reg_s = (op_q_r == CLS_LH);
                retire_s     = 1'b1;
            end
            ST_ILLEGAL: begin
                busy_s = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                illegal_s = 1'b1;
`endif
            end
            default: busy_s = 1'b0;
        endcase
    end

    assign ctrl.ir_write   = ir_write_s;
    assign ctrl.pc_write   = pc_write_s;
    assign ctrl.alu_op     = alu_op_s;
    assign ctrl.alu_src    = alu_src_s;
    assign ctrl.branch     = branch_s;
    assign ctrl.mem_read   = mem_read_s;
    assign ctrl.mem_write  = mem_write_s;
    assign ctrl.reg_write  = reg_write_s;
    assign ctrl.mem_to_reg = mem_to_reg_s;
    assign ctrl.retire     = retire_s;
    assign ctrl.busy       = busy_s;
    assign ctrl.illegal    = illegal_s;

endmodule
